// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's load/store port.
// One request at a time over valid/ready, byte/half/word little-endian lanes,
// LATENCY wait states (0..15), sign/zero-extended load data and an error flag.
// Optional build macro: DMEM_MISALIGN_CHECK_EN (misaligned H/HU/W become errors;
// otherwise they are silently aligned down).
//
// state  | meaning
// S_IDLE | ready for a request; accepts and registers it when req_valid
// S_WAIT | counting down wait states; executes the access when counter is 0
// S_RESP | response held on rsp_* until rsp_ready
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        r_we;
  logic [2:0]  r_size;
  logic [31:0] r_addr, r_wdata;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, exec;
  logic          ex_we;
  logic [2:0]    ex_size;
  logic [31:0]   ex_addr, ex_wdata;
  logic [AW-1:0] ex_idx;
  logic [31:0]   ex_word, ex_lanes, ex_rdata;
  logic [7:0]    ex_byte;
  logic [15:0]   ex_half;
  logic [3:0]    ex_mask;
  logic          ex_err;

  assign accept = (state == S_IDLE) && req_valid;
  // with zero wait states the access runs on the accept edge from the live inputs
  assign exec   = (accept && (LATENCY == 0)) || ((state == S_WAIT) && (cnt == 4'd0));

  assign ex_we    = (state == S_IDLE) ? req_we    : r_we;
  assign ex_size  = (state == S_IDLE) ? req_size  : r_size;
  assign ex_addr  = (state == S_IDLE) ? req_addr  : r_addr;
  assign ex_wdata = (state == S_IDLE) ? req_wdata : r_wdata;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // access decode: lane mask, store lanes, extended load data, error
  always_comb begin
    ex_err   = 1'b0;
    ex_mask  = 4'b0000;
    ex_lanes = 32'd0;
    ex_rdata = 32'd0;
    ex_idx   = ex_addr[AW+1:2];
    ex_word  = mem[ex_idx];
    ex_byte  = 8'(ex_word >> {ex_addr[1:0], 3'b000});
    ex_half  = ex_addr[1] ? ex_word[31:16] : ex_word[15:0];
    case (ex_size)
      3'b000, 3'b100: begin
        ex_mask  = 4'b0001 << ex_addr[1:0];
        ex_lanes = {4{ex_wdata[7:0]}};
        ex_rdata = ex_size[2] ? {24'd0, ex_byte} : {{24{ex_byte[7]}}, ex_byte};
      end
      3'b001, 3'b101: begin
        ex_mask  = ex_addr[1] ? 4'b1100 : 4'b0011;
        ex_lanes = {2{ex_wdata[15:0]}};
        ex_rdata = ex_size[2] ? {16'd0, ex_half} : {{16{ex_half[15]}}, ex_half};
      end
      3'b010: begin
        ex_mask  = 4'b1111;
        ex_lanes = ex_wdata;
        ex_rdata = ex_word;
      end
      default: ex_err = 1'b1;
    endcase
    if (ex_we && ex_size[2]) ex_err = 1'b1;
    if (ex_addr[31:2] >= 30'(DEPTH_WORDS)) ex_err = 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((ex_size[1:0] == 2'b01 && ex_addr[0]) ||
        (ex_size == 3'b010 && ex_addr[1:0] != 2'b00)) ex_err = 1'b1;
`endif
    if (ex_err || ex_we) ex_rdata = 32'd0;
    if (ex_err) ex_mask = 4'b0000;
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // request capture, wait-state counter and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        cnt     <= (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (exec) begin
        rdata_q <= ex_rdata;
        err_q   <= ex_err;
      end
    end
  end

  // array write; contents survive reset, but no write can happen while in reset
  always_ff @(posedge clk) begin
    if (exec && reset && ex_we && !ex_err) begin
      for (int i = 0; i < 4; i++) begin
        if (ex_mask[i]) mem[ex_idx][8*i +: 8] <= ex_lanes[8*i +: 8];
      end
    end
  end

endmodule
